// File: rtl/fetch_exc_pkg.sv
// Shared types and constants for the exception-capable fetch stage.
// The state enum, the next-PC select codes and the internal cause codes live here.
package fetch_exc_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        HANDLER = 2'd1,
        HALT    = 2'd2
    } fetch_state_t;

    typedef enum logic [2:0] {
        SEL_SEQ    = 3'd0,
        SEL_HOLD   = 3'd1,
        SEL_BRANCH = 3'd2,
        SEL_VECTOR = 3'd3,
        SEL_ERET   = 3'd4
    } pc_sel_t;

    localparam logic [3:0] CAUSE_MISALIGN     = 4'hF;
    localparam logic [3:0] CAUSE_ILLEGAL_ERET = 4'hE;

    // An externally raised exception always reports its own cause code.
    function automatic logic [3:0] pick_cause(input logic       ext_exc,
                                              input logic [3:0] ext_cause,
                                              input logic       misalign);
        if (ext_exc)
            return ext_cause;
        else if (misalign)
            return CAUSE_MISALIGN;
        else
            return CAUSE_ILLEGAL_ERET;
    endfunction

endpackage

// File: rtl/fetch_exc_ctrl.sv
// Handler-mode FSM and next-PC priority decode for the fetch stage.
// Produces the PC select, the ELR/ESR capture strobe and the mode flags.
module fetch_exc_ctrl
    import fetch_exc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       pcsrc,
    input  logic [1:0] branch_lo,
    input  logic       exc,
    input  logic [3:0] exc_cause,
    input  logic       eret,
    input  logic       stall,
    output pc_sel_t    pc_sel,
    output logic       exc_entry,
    output logic [3:0] cause,
    output logic       in_handler,
    output logic       halt
);

    fetch_state_t state_reg;
    fetch_state_t state_next;

    logic misalign;
    logic illegal_eret;
    logic exc_any;

    assign misalign     = pcsrc & (branch_lo != 2'b00);
    assign illegal_eret = eret & (state_reg == RUN);
    assign exc_any      = exc | misalign | illegal_eret;
    assign cause        = pick_cause(exc, exc_cause, misalign);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_reg <= RUN;
        else
            state_reg <= state_next;
    end

    // HALT is absorbing; only reset leaves it.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RUN:     if (exc_any) state_next = HANDLER;
            HANDLER: begin
                if (exc_any)
                    state_next = HALT;
                else if (eret)
                    state_next = RUN;
            end
            HALT:    state_next = HALT;
            default: state_next = RUN;
        endcase
    end

    // Exceptions and ERet ignore stall; stall only blocks the sequential/branch update.
    always_comb begin
        pc_sel    = SEL_HOLD;
        exc_entry = 1'b0;
        case (state_reg)
            RUN: begin
                if (exc_any) begin
                    pc_sel    = SEL_VECTOR;
                    exc_entry = 1'b1;
                end else if (stall)
                    pc_sel = SEL_HOLD;
                else if (pcsrc)
                    pc_sel = SEL_BRANCH;
                else
                    pc_sel = SEL_SEQ;
            end
            HANDLER: begin
                if (exc_any)
                    pc_sel = SEL_HOLD;
                else if (eret)
                    pc_sel = SEL_ERET;
                else if (stall)
                    pc_sel = SEL_HOLD;
                else if (pcsrc)
                    pc_sel = SEL_BRANCH;
                else
                    pc_sel = SEL_SEQ;
            end
            default: pc_sel = SEL_HOLD;
        endcase
    end

    assign in_handler = (state_reg == HANDLER);
    assign halt       = (state_reg == HALT);

endmodule

// File: rtl/fetch_exc.sv
// Fetch stage with exception support: PC, ELR and ESR registers plus the next-PC mux.
// Sequencing and priority come from fetch_exc_ctrl.
module fetch_exc
    import fetch_exc_pkg::*;
#(
    parameter int          N          = 64,
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter logic [63:0] EXC_VECTOR = 64'hD8,
    parameter int          ERET_SKIP  = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         PCSrc_F,
    input  logic [N-1:0] PCBranch_F,
    input  logic         Exc_F,
    input  logic [3:0]   ExcCause_F,
    input  logic         ERet_F,
    input  logic         Stall_F,
    output logic [N-1:0] imem_addr_F,
    output logic [N-1:0] ELR_F,
    output logic [3:0]   ESR_F,
    output logic         InHandler_F,
    output logic         Halt_F
);

    localparam logic [N-1:0] RESET_VAL = RESET_PC[N-1:0];
    localparam logic [N-1:0] VECTOR    = EXC_VECTOR[N-1:0];
    localparam logic [N-1:0] STEP      = N'(4);
    localparam logic [N-1:0] ERET_OFS  = (ERET_SKIP != 0) ? STEP : '0;

    logic [N-1:0] pc_reg,  pc_next;
    logic [N-1:0] elr_reg;
    logic [3:0]   esr_reg;

    pc_sel_t    pc_sel;
    logic       exc_entry;
    logic [3:0] cause;

    fetch_exc_ctrl u_ctrl (
        .clk        (clk),
        .reset      (reset),
        .pcsrc      (PCSrc_F),
        .branch_lo  (PCBranch_F[1:0]),
        .exc        (Exc_F),
        .exc_cause  (ExcCause_F),
        .eret       (ERet_F),
        .stall      (Stall_F),
        .pc_sel     (pc_sel),
        .exc_entry  (exc_entry),
        .cause      (cause),
        .in_handler (InHandler_F),
        .halt       (Halt_F)
    );

    // N-bit adders give the required modulo-2^N wrap for free.
    always_comb begin
        pc_next = pc_reg;
        case (pc_sel)
            SEL_SEQ:    pc_next = pc_reg + STEP;
            SEL_BRANCH: pc_next = PCBranch_F;
            SEL_VECTOR: pc_next = VECTOR;
            SEL_ERET:   pc_next = elr_reg + ERET_OFS;
            default:    pc_next = pc_reg;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_reg  <= RESET_VAL;
            elr_reg <= '0;
            esr_reg <= '0;
        end else begin
            pc_reg <= pc_next;
            if (exc_entry) begin
                elr_reg <= pc_reg;
                esr_reg <= cause;
            end
        end
    end

    assign imem_addr_F = pc_reg;
    assign ELR_F       = elr_reg;
    assign ESR_F       = esr_reg;

endmodule

// File: tb/tb_fetch_exc.sv
// Directed bench for fetch_exc: a 64-bit instance and a 16-bit ERET_SKIP=1 instance share stimulus.
// A behavioural model is compared every cycle; literal checks pin the model at key points.
module tb_fetch_exc;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pcsrc = 1'b0;
    logic [63:0] branch = 64'h0;
    logic        exc = 1'b0;
    logic [3:0]  cause = 4'h0;
    logic        eret = 1'b0;
    logic        stall = 1'b0;

    logic [63:0] pc_a, elr_a;
    logic [15:0] pc_b, elr_b;
    logic [3:0]  esr_a, esr_b;
    logic        inh_a, inh_b, halt_a, halt_b;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    // model: index 0 = 64-bit ERET_SKIP=0, index 1 = 16-bit ERET_SKIP=1
    longint unsigned m_pc[2], m_elr[2], m_esr[2];
    int              m_mode[2];   // 0 run, 1 handler, 2 halted
    longint unsigned mask[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF};
    longint unsigned skip[2] = '{0, 4};

    always #5 clk = ~clk;

    fetch_exc #(.N(64)) dut_a (
        .clk(clk), .reset(reset), .PCSrc_F(pcsrc), .PCBranch_F(branch),
        .Exc_F(exc), .ExcCause_F(cause), .ERet_F(eret), .Stall_F(stall),
        .imem_addr_F(pc_a), .ELR_F(elr_a), .ESR_F(esr_a),
        .InHandler_F(inh_a), .Halt_F(halt_a)
    );

    fetch_exc #(.N(16), .ERET_SKIP(1)) dut_b (
        .clk(clk), .reset(reset), .PCSrc_F(pcsrc), .PCBranch_F(branch[15:0]),
        .Exc_F(exc), .ExcCause_F(cause), .ERet_F(eret), .Stall_F(stall),
        .imem_addr_F(pc_b), .ELR_F(elr_b), .ESR_F(esr_b),
        .InHandler_F(inh_b), .Halt_F(halt_b)
    );

    function automatic void check(input string name, input longint unsigned act,
                                  input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_pc[k] = 0; m_elr[k] = 0; m_esr[k] = 0; m_mode[k] = 0;
        end
    end

    always @(posedge clk or posedge reset) begin
        bit misal, ill, fault;
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                m_pc[k] <= 0; m_elr[k] <= 0; m_esr[k] <= 0; m_mode[k] <= 0;
            end
        end else begin
            misal = pcsrc && (branch[1:0] != 2'b00);
            for (int k = 0; k < 2; k++) begin
                ill   = eret && (m_mode[k] == 0);
                fault = exc || misal || ill;
                if (m_mode[k] == 2) begin
                    // halted: nothing moves
                end else if (fault && m_mode[k] == 1) begin
                    m_mode[k] <= 2;
                end else if (fault) begin
                    m_elr[k]  <= m_pc[k];
                    m_esr[k]  <= exc ? cause : (misal ? 4'hF : 4'hE);
                    m_pc[k]   <= 64'hD8 & mask[k];
                    m_mode[k] <= 1;
                end else if (eret) begin
                    m_pc[k]   <= (m_elr[k] + skip[k]) & mask[k];
                    m_mode[k] <= 0;
                end else if (!stall) begin
                    m_pc[k] <= pcsrc ? (branch & mask[k]) : ((m_pc[k] + 4) & mask[k]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("a.pc",   pc_a,   m_pc[0]);
            check("a.elr",  elr_a,  m_elr[0]);
            check("a.esr",  esr_a,  m_esr[0]);
            check("a.inh",  inh_a,  (m_mode[0] == 1) ? 1 : 0);
            check("a.halt", halt_a, (m_mode[0] == 2) ? 1 : 0);
            check("b.pc",   pc_b,   m_pc[1]);
            check("b.elr",  elr_b,  m_elr[1]);
            check("b.esr",  esr_b,  m_esr[1]);
            check("b.inh",  inh_b,  (m_mode[1] == 1) ? 1 : 0);
            check("b.halt", halt_b, (m_mode[1] == 2) ? 1 : 0);
        end
    end

    // Called at a negedge: apply inputs, let one rising edge pass, return at the next negedge.
    task automatic drive(input string label, input bit p, input longint unsigned br,
                         input bit e, input logic [3:0] c, input bit r, input bit s);
        pcsrc = p; branch = br; exc = e; cause = c; eret = r; stall = s;
        @(negedge clk);
        $display("%-10s pc_a=%h pc_b=%h elr_a=%h esr_a=%h inh=%b halt=%b",
                 label, pc_a, pc_b, elr_a, esr_a, inh_a, halt_a);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive("idle", 0, 0, 0, 4'h0, 0, 0);
    endtask

    initial begin
        repeat (5) @(negedge clk);
        check("rst.pc",   pc_a, 0);
        check("rst.elr",  elr_a, 0);
        check("rst.esr",  esr_a, 0);
        check("rst.inh",  inh_a, 0);
        check("rst.halt", halt_a, 0);
        cmp_en = 1'b1;
        reset = 1'b0;

        idle(20);
        check("seq.a", pc_a, 80);
        check("seq.b", pc_b, 80);

        drive("branch", 1, 69856, 0, 4'h0, 0, 0);
        check("br.a", pc_a, 69856);
        check("br.b", pc_b, 16'h10E0);
        drive("stall", 0, 0, 0, 4'h0, 0, 1);
        drive("stall+br", 1, 64'h300, 0, 4'h0, 0, 1);
        drive("stall", 0, 0, 0, 4'h0, 0, 1);
        check("stall.a", pc_a, 69856);

        drive("branch", 1, 64'h20, 0, 4'h0, 0, 0);
        drive("misalign", 1, 69857, 0, 4'h0, 0, 0);
        check("mis.pc", pc_a, 64'hD8);
        check("mis.elr", elr_a, 64'h20);
        check("mis.esr", esr_a, 4'hF);
        check("mis.inh", inh_a, 1);
        drive("eret", 0, 0, 0, 4'h0, 1, 0);
        check("ret.a", pc_a, 64'h20);
        check("ret.b", pc_b, 16'h24);
        check("ret.inh", inh_a, 0);

        drive("branch", 1, 64'h40, 0, 4'h0, 0, 0);
        drive("exc+stall", 0, 0, 1, 4'h3, 0, 1);
        check("exc.pc", pc_a, 64'hD8);
        check("exc.esr", esr_a, 4'h3);
        check("exc.elr", elr_a, 64'h40);
        idle(2);
        check("hnd.seq", pc_a, 64'hE0);
        drive("eret+br", 1, 64'h100, 0, 4'h0, 1, 0);
        check("eret.a", pc_a, 64'h40);
        check("eret.b", pc_b, 16'h44);

        drive("branch", 1, 64'h10, 0, 4'h0, 0, 0);
        drive("bad_eret", 0, 0, 0, 4'h0, 1, 0);
        check("ill.pc", pc_a, 64'hD8);
        check("ill.esr", esr_a, 4'hE);
        check("ill.elr", elr_a, 64'h10);
        check("ill.inh", inh_a, 1);

        drive("dbl_fault", 1, 64'h100, 1, 4'h7, 1, 0);
        check("dbl.halt", halt_a, 1);
        check("dbl.pc", pc_a, 64'hD8);
        check("dbl.esr", esr_a, 4'hE);
        for (int i = 0; i < 10; i++)
            drive("halted", i[0], 64'h200, i[1], 4'h9, i[2], 0);
        check("halt.pc", pc_a, 64'hD8);
        check("halt.elr", elr_a, 64'h10);
        check("halt.sticky", halt_a, 1);

        #2 reset = 1'b1;
        #1;
        check("arst.pc", pc_a, 0);
        check("arst.halt", halt_a, 0);
        check("arst.elr", elr_a, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        drive("exc+mis", 1, 64'h102, 1, 4'h5, 0, 0);
        check("prio.esr", esr_a, 4'h5);
        check("prio.elr", elr_a, 0);
        drive("eret", 0, 0, 0, 4'h0, 1, 0);
        check("prio.ret.b", pc_b, 16'h4);

        drive("branch", 1, 64'hFFFC, 0, 4'h0, 0, 0);
        idle(1);
        check("wrap.b", pc_b, 0);
        check("wrap.a16", pc_a, 64'h10000);
        drive("branch", 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 4'h0, 0, 0);
        idle(1);
        check("wrap.a", pc_a, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_exc.md
# fetch_exc

Parametrised successor to the single-cycle fetch stage, for the exceptions-capable ARM (LEGv8) processor. It holds the PC register and selects the next PC from:
- sequential PC+4,
- a branch target,
- an exception vector,
- an exception return.

It also owns the exception link/syndrome registers, a handler-mode FSM with double-fault halt, stall support, and misaligned-branch detection. It sits between the datapath control (PCSrc, Exc, ERet, Stall) and the instruction memory address port.

## Interface
Parameters:
- N, 64, PC/address width (N ≥ 8)
- RESET_PC, 0, PC value after reset
- EXC_VECTOR, 64'hD8, handler entry address (truncated to N)
- ERET_SKIP, 0, 0: ERet resumes at ELR; 1: ERet resumes at ELR+4

Ports (one clock; reset is asynchronous and active-high, ports named clk and reset):
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- PCSrc_F  in  1  take branch target
- PCBranch_F  in  N  branch target
- Exc_F  in  1  exception raised by instruction at current PC
- ExcCause_F  in  4  cause code accompanying Exc_F
- ERet_F  in  1  return-from-exception
- Stall_F  in  1  hold PC (sequential/branch update only)
- imem_addr_F  out  N  current PC, registered
- ELR_F  out  N  exception link register
- ESR_F  out  4  exception syndrome (cause)
- InHandler_F  out  1  FSM in HANDLER
- Halt_F  out  1  FSM in HALT

## Operation
- FSM states: RUN, HANDLER, HALT. Reset → RUN.
- Effective exception: `exc = Exc_F | misalign | illegal_eret`.
  - `misalign = PCSrc_F & (PCBranch_F[1:0] != 0)`, cause 4'hF.
  - `illegal_eret = ERet_F` in RUN, cause 4'hE.
  - When Exc_F is asserted together with either internal cause, ExcCause_F wins.
- Per-cycle priority, highest first:
  1. HALT: everything held.
  2. exc in HANDLER: go to HALT, PC held, ELR/ESR unchanged.
  3. exc in RUN: ELR←PC, ESR←cause, PC←EXC_VECTOR, go to HANDLER.
  4. ERet_F in HANDLER: PC←ELR (+4 if ERET_SKIP), go to RUN.
  5. Stall_F: PC held.
  6. PCSrc_F: PC←PCBranch_F.
  7. Otherwise: PC←PC+4.
- Exceptions and ERet act regardless of Stall_F.
- All PC arithmetic is modulo 2^N; PC+4 at 2^N−4 wraps to 0.
- ELR/ESR are written only on entry to HANDLER.

## Timing
- Reset values:
  - imem_addr_F = RESET_PC
  - ELR_F = 0, ESR_F = 0
  - InHandler_F = 0, Halt_F = 0
- Reset asserted mid-handler or in HALT returns to RUN with all reset values, immediately (asynchronous).
- All outputs are registered; each decision is made on the inputs sampled at the rising edge and is visible on imem_addr_F after that edge (1-cycle latency).
- InHandler_F and Halt_F change on the same edge as the PC redirect.
- Halt is sticky until reset.
- In HANDLER, ERet_F on the same edge as PCSrc_F: the ERet wins. Exc_F on that same edge wins over both (double fault).

## Structure
- Package `fetch_exc_pkg`:
  - `fetch_state_t` enum (RUN, HANDLER, HALT)
  - cause constants `CAUSE_MISALIGN` = 4'hF, `CAUSE_ILLEGAL_ERET` = 4'hE
- Sub-module `fetch_exc_ctrl`: FSM plus priority decode. It outputs the next-PC select and the ELR/ESR write enable.
- Top level holds the PC/ELR/ESR registers and the next-PC mux.

## Test plan
- **Sequential fetch:** reset for 5 cycles, then 20 cycles idle → imem_addr_F goes 0, 4, 8, …, 80.
- **Branch and stall:**
  - PCSrc_F=1, PCBranch_F=69856 for one cycle → next PC 69856.
  - Stall_F=1 for 3 cycles → PC stays 69856.
- **Misaligned branch:** at PC=0x20, PCBranch_F=69857 → PC=0xD8, ELR_F=0x20, ESR_F=0xF, InHandler_F=1.
- **Exception and return:**
  - Exc_F at PC=0x40, cause 4'h3 → PC=0xD8, ESR_F=3.
  - Later ERet_F → PC=0x40, or 0x44 with ERET_SKIP=1.
  - InHandler_F drops on the same edge.
- **Double fault and illegal ERet:**
  - Exc_F while in HANDLER → Halt_F=1, PC frozen for 10 cycles; reset → PC=RESET_PC, Halt_F=0.
  - ERet_F in RUN at PC=0x10 → PC=0xD8, ESR_F=0xE, ELR_F=0x10.
- **Wrap-around and width:** N=16, PC forced via branch to 0xFFFC → next PC 0x0000.
